pattern_tx: RTL

Serial pattern transmitter: the stimulus-side counterpart of the team's Moore sequence detector. It accepts a pattern command through a valid/ready handshake and drives the one-bit serial line `x`, MSB first, one bit per clock. Each command sends pattern A (10001, detector code 01) or pattern B (10101, detector code 11), repeated a programmable number of times, with mandatory zero gaps between repeats. It also outputs the detector response it expects (`exp_y`), so a bench or on-chip self-test can loop it back against the detector.

---
 rtl/pattern_tx_pkg.sv | 35 +++
 rtl/pattern_tx_sat_cnt.sv | 35 +++
 rtl/pattern_tx.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pattern_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pattern_tx_pkg
// Description : Shared types and constants for the serial pattern transmitter.
//               FSM state enum, command codes, pattern bit strings and the
//               pattern-select helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pattern_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_NOP  = 2'd3
    } state_t;

    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_A   = 2'b01;
    localparam logic [1:0] CMD_RSV = 2'b10;
    localparam logic [1:0] CMD_B   = 2'b11;

    localparam int PAT_LEN = 5;

    localparam logic [PAT_LEN-1:0] PAT_A = 5'b10001;
    localparam logic [PAT_LEN-1:0] PAT_B = 5'b10101;

    // Only called with CMD_A / CMD_B in a meaningful way; other codes never
    // reach the SEND state, so the fallback value is irrelevant.
    function automatic logic [PAT_LEN-1:0] pat_of(input logic [1:0] code);
        return (code == CMD_B) ? PAT_B : PAT_A;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_tx_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : pattern_tx_sat_cnt
// Description : Saturating up-counter with increment enable. Sticks at
//               all-ones; cleared only by reset.
// Ports       : clk, rst   - clock, synchronous active-high reset
//               i_inc      - increment request
//               o_count    - current count (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_tx_sat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] c_ONE = 1;

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pattern_tx.sv
`default_nettype none
// ============================================================================
// Module      : pattern_tx
// Description : Serial pattern transmitter. Accepts a command over a
//               valid/ready handshake and shifts pattern A (10001) or
//               B (10101) out MSB first, rpt+1 times, each followed by GAP
//               zero bits. Also drives the Moore detector response expected
//               for the transmitted stream (exp_y).
// Ports       : clk, rst        - clock, synchronous active-high reset
//               cmd_valid/ready - command handshake (ready only in IDLE)
//               cmd, rpt        - pattern select, additional repeat count
//               x               - serial data out
//               busy            - SEND or GAP in progress
//               exp_y           - expected detector output
//               done, err       - completion / reserved-command pulses
//               sent_cnt        - completed-pattern count
// Config      : PATTERN_TX_CNT_EN - build the saturating sent_cnt counter;
//               when undefined sent_cnt is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int GAP   = 4,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd,
    input  logic [REP_W-1:0] rpt,
    output logic             x,
    output logic             busy,
    output logic [1:0]       exp_y,
    output logic             done,
    output logic             err,
    output logic [15:0]      sent_cnt
);

    localparam logic [3:0]       c_GAP_LAST = 4'(GAP - 1);
    localparam logic [2:0]       c_BIT_LAST = 3'(PAT_LEN - 1);
    localparam logic [REP_W-1:0] c_REP_ONE  = 1;

    state_t             r_state;
    logic [PAT_LEN-1:0] r_shift;
    logic [2:0]         r_bit;
    logic [3:0]         r_gap;
    logic [REP_W-1:0]   r_rpt;
    logic [1:0]         r_code;

    logic               r_x;
    logic               r_busy;
    logic               r_ready;
    logic [1:0]         r_exp_y;
    logic               r_done;
    logic               r_err;

    state_t             w_state_nxt;
    logic [PAT_LEN-1:0] w_shift_nxt;
    logic [2:0]         w_bit_nxt;
    logic [3:0]         w_gap_nxt;
    logic [REP_W-1:0]   w_rpt_nxt;
    logic [1:0]         w_code_nxt;
    logic               w_first_gap;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_bit   <= '0;
            r_gap   <= '0;
            r_rpt   <= '0;
            r_code  <= CMD_NOP;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_bit   <= w_bit_nxt;
            r_gap   <= w_gap_nxt;
            r_rpt   <= w_rpt_nxt;
            r_code  <= w_code_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit;
        w_gap_nxt   = r_gap;
        w_rpt_nxt   = r_rpt;
        w_code_nxt  = r_code;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_code_nxt  = cmd;
                    w_rpt_nxt   = rpt;
                    w_shift_nxt = pat_of(cmd);
                    w_bit_nxt   = c_BIT_LAST;
                    if ((cmd == CMD_A) || (cmd == CMD_B)) begin
                        w_state_nxt = ST_SEND;
                    end else begin
                        w_state_nxt = ST_NOP;
                    end
                end
            end
            ST_SEND: begin
                if (r_bit == 3'd0) begin
                    w_state_nxt = ST_GAP;
                    w_gap_nxt   = c_GAP_LAST;
                end else begin
                    w_shift_nxt = r_shift << 1;
                    w_bit_nxt   = r_bit - 3'd1;
                end
            end
            ST_GAP: begin
                if (r_gap == 4'd0) begin
                    if (r_rpt != '0) begin
                        w_rpt_nxt   = r_rpt - c_REP_ONE;
                        w_shift_nxt = pat_of(r_code);
                        w_bit_nxt   = c_BIT_LAST;
                        w_state_nxt = ST_SEND;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_gap_nxt = r_gap - 4'd1;
                end
            end
            ST_NOP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // The SEND->GAP transition marks the first gap cycle: the detector has
    // just sampled the last pattern bit, so its Moore output shows the code.
    assign w_first_gap = (r_state == ST_SEND) && (w_state_nxt == ST_GAP);

    // ------------------------------------------------------------------
    // Output registers, decoded from the next state so every output is a
    // flop and still lines up with the state it describes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_exp_y <= 2'b00;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_x     <= (w_state_nxt == ST_SEND) && w_shift_nxt[PAT_LEN-1];
            r_busy  <= (w_state_nxt == ST_SEND) || (w_state_nxt == ST_GAP);
            r_ready <= (w_state_nxt == ST_IDLE);
            r_exp_y <= w_first_gap ? r_code : 2'b00;
            r_done  <= (w_state_nxt == ST_NOP) ||
                       ((w_state_nxt == ST_GAP) && (w_gap_nxt == 4'd0) && (w_rpt_nxt == '0));
            r_err   <= (w_state_nxt == ST_NOP) && (w_code_nxt == CMD_RSV);
        end
    end

    assign x         = r_x;
    assign busy      = r_busy;
    assign cmd_ready = r_ready;
    assign exp_y     = r_exp_y;
    assign done      = r_done;
    assign err       = r_err;

`ifdef PATTERN_TX_CNT_EN
    pattern_tx_sat_cnt #(
        .WIDTH (16)
    ) u_sent_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_first_gap),
        .o_count (sent_cnt)
    );
`else
    assign sent_cnt = 16'd0;
`endif

endmodule
`default_nettype wire
